// File: rtl/im2col_window_gen.sv
// im2col_window_gen: walks a KxK stride-1 window across an IMG_H x IMG_W image
// held in the upstream im2col buffer. It drives the buffer's top-row address,
// captures one window per accepted cycle in raster order, and pulses
// o_buf_ready when the last window of the image is captured.
// Optional build macro IM2COL_TAG_EN adds o_win_row/o_win_col/o_win_last tags.
module im2col_window_gen #(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28,
  parameter int K     = 3,
  parameter int DW    = 8
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic                             i_buf_valid,
  output logic                             o_buf_ready,
  output logic [$clog2(IMG_H)-1:0]         o_addr,
  input  logic [K-1:0][IMG_W-1:0][DW-1:0]  i_rows,
  output logic                             o_win_valid,
  input  logic                             i_win_ready,
  output logic [K-1:0][K-1:0][DW-1:0]      o_win
`ifdef IM2COL_TAG_EN
  ,
  output logic [$clog2(IMG_H)-1:0]         o_win_row,
  output logic [$clog2(IMG_W)-1:0]         o_win_col,
  output logic                             o_win_last
`endif
);

  localparam int RW = $clog2(IMG_H);
  localparam int CW = $clog2(IMG_W);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - K);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - K);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t                      state;
  state_t                      state_next;
  logic [RW-1:0]               row;
  logic [CW-1:0]               col;
  logic                        image_done;
  logic                        load;
  logic                        last_pos;
  logic [K-1:0][K-1:0][DW-1:0] win_next;

  // Load qualification and the same-cycle buffer release on the final load
  always_comb begin
    last_pos    = (row == ROW_LAST) && (col == COL_LAST);
    load        = (state == RUN) && i_buf_valid && (!o_win_valid || i_win_ready);
    o_buf_ready = load && last_pos;
    o_addr      = row;
  end

  // Select the KxK window starting at the current column from the buffer slice
  always_comb begin
    win_next = '0;
    for (int unsigned r = 0; r < K; r++) begin
      for (int unsigned c = 0; c < K; c++) begin
        win_next[r][c] = i_rows[r][col + CW'(c)];
      end
    end
  end

  // Next-state logic: leave RUN only once an image finished and no new one is offered
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (i_buf_valid) state_next = RUN;
      RUN:  if (image_done && !i_buf_valid) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register plus a flag remembering that the last window has been captured
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= IDLE;
      image_done <= 1'b0;
    end else begin
      state <= state_next;
      if (load) begin
        image_done <= last_pos;
      end else if (state == IDLE) begin
        image_done <= 1'b0;
      end
    end
  end

  // Window register, valid handshake and raster counters
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      row         <= '0;
      col         <= '0;
      o_win       <= '0;
      o_win_valid <= 1'b0;
    end else if (load) begin
      o_win       <= win_next;
      o_win_valid <= 1'b1;
      if (col == COL_LAST) begin
        col <= '0;
        if (row == ROW_LAST) begin
          row <= '0;
        end else begin
          row <= row + RW'(1);
        end
      end else begin
        col <= col + CW'(1);
      end
    end else if (i_win_ready && o_win_valid) begin
      o_win_valid <= 1'b0;
    end
  end

`ifdef IM2COL_TAG_EN
  // Position tags registered alongside the window they describe
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_win_row  <= '0;
      o_win_col  <= '0;
      o_win_last <= 1'b0;
    end else if (load) begin
      o_win_row  <= row;
      o_win_col  <= col;
      o_win_last <= last_pos;
    end
  end
`endif

endmodule

// File: tb/tb_im2col_window_gen.sv
// Self-checking bench for im2col_window_gen. Image content is a per-image random
// base plus the raster index of each pixel; expected windows are computed from
// the global window index alone.
module tb_im2col_window_gen;

  localparam int IMG_W = 28;
  localparam int IMG_H = 28;
  localparam int K     = 3;
  localparam int DW    = 8;
  localparam int WPR   = IMG_W - K + 1;
  localparam int NWIN  = (IMG_H - K + 1) * WPR;
  localparam int LIMIT = 6000;

  typedef logic [K-1:0][K-1:0][DW-1:0] win_t;

  logic                            i_clk;
  logic                            i_rst;
  logic                            i_buf_valid;
  logic                            o_buf_ready;
  logic [4:0]                      o_addr;
  logic [K-1:0][IMG_W-1:0][DW-1:0] i_rows;
  logic                            o_win_valid;
  logic                            i_win_ready;
  win_t                            o_win;
`ifdef IM2COL_TAG_EN
  logic [4:0]                      o_win_row;
  logic [4:0]                      o_win_col;
  logic                            o_win_last;
`endif

  im2col_window_gen #(.IMG_W(IMG_W), .IMG_H(IMG_H), .K(K), .DW(DW)) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_buf_valid(i_buf_valid),
    .o_buf_ready(o_buf_ready),
    .o_addr     (o_addr),
    .i_rows     (i_rows),
    .o_win_valid(o_win_valid),
    .i_win_ready(i_win_ready),
    .o_win      (o_win)
`ifdef IM2COL_TAG_EN
    ,
    .o_win_row  (o_win_row),
    .o_win_col  (o_win_col),
    .o_win_last (o_win_last)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  int img_base [4];
  int cur_img;
  bit switch_pending;
  int consumed;
  int pulses;

  logic       s_valid;
  win_t       s_win;
  logic       s_bready;
  logic [4:0] s_addr;
`ifdef IM2COL_TAG_EN
  logic [4:0] s_row;
  logic [4:0] s_col;
  logic       s_last;
`endif

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  function automatic logic [DW-1:0] pix(int base, int r, int c);
    int v;
    v = (base + r * IMG_W + c) % 256;
    return DW'(v);
  endfunction

  // Buffer model: slice rows o_addr..o_addr+K-1 of the current image
  always_comb begin
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < IMG_W; c++) begin
        i_rows[r][c] = pix(img_base[cur_img], int'(o_addr) + r, c);
      end
    end
  end

  function automatic win_t exp_win(int n);
    win_t e;
    int img, w, row, col;
    img = n / NWIN;
    w   = n % NWIN;
    row = w / WPR;
    col = w % WPR;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K; c++) begin
        e[r][c] = pix(img_base[img], row + r, col + c);
      end
    end
    return e;
  endfunction

  // Drive one cycle's inputs at the falling edge and sample outputs just after
  task automatic tick(input bit rdy, input bit vld);
    @(negedge i_clk);
    if (switch_pending) begin
      cur_img        = cur_img + 1;
      switch_pending = 1'b0;
    end
    i_win_ready = rdy;
    i_buf_valid = vld;
    #1;
    s_valid  = o_win_valid;
    s_win    = o_win;
    s_bready = o_buf_ready;
    s_addr   = o_addr;
`ifdef IM2COL_TAG_EN
    s_row  = o_win_row;
    s_col  = o_win_col;
    s_last = o_win_last;
`endif
    if (s_bready) switch_pending = 1'b1;
  endtask

  task automatic clear_model();
    cur_img        = 0;
    switch_pending = 1'b0;
    consumed       = 0;
    pulses         = 0;
  endtask

  task automatic apply_reset();
    @(negedge i_clk);
    i_rst       = 1'b1;
    i_buf_valid = 1'b0;
    i_win_ready = 1'b0;
    @(negedge i_clk);
    i_rst = 1'b0;
    clear_model();
  endtask

  task automatic test_reset();
    i_rst       = 1'b1;
    i_buf_valid = 1'b0;
    i_win_ready = 1'b0;
    clear_model();
    repeat (2) @(negedge i_clk);
    #1;
    n_cmp++;
    if (o_win_valid !== 1'b0 || o_addr !== 5'd0 || o_buf_ready !== 1'b0 || o_win !== '0) begin
      n_err++;
      $display("FAIL reset: valid=%b addr=%0d bready=%b win=%h, required 0/0/0/0",
               o_win_valid, o_addr, o_buf_ready, o_win);
    end
`ifdef IM2COL_TAG_EN
    n_cmp++;
    if (o_win_row !== 5'd0 || o_win_col !== 5'd0 || o_win_last !== 1'b0) begin
      n_err++;
      $display("FAIL reset_tags: row=%0d col=%0d last=%b, required 0/0/0", o_win_row, o_win_col, o_win_last);
    end
`endif
    @(negedge i_clk);
    i_rst = 1'b0;
    // Idle with no image offered: nothing may appear
    repeat (3) tick(1'b1, 1'b0);
    n_cmp++;
    if (s_valid !== 1'b0 || s_bready !== 1'b0) begin
      n_err++;
      $display("FAIL idle: valid=%b bready=%b, required 0/0", s_valid, s_bready);
    end
  endtask

  task automatic test_single_image();
    win_t e;
    int   w;
    apply_reset();
    img_base[0] = 0;
    img_base[1] = 0;
    for (int t = 0; t < LIMIT && consumed < NWIN; t++) begin
      tick(1'b1, pulses < 1);
      if (s_bready) begin
        n_cmp++;
        if (s_addr !== 5'd25 || ((consumed + int'(s_valid)) % NWIN) != NWIN - 1) begin
          n_err++;
          $display("FAIL single_release: addr=%0d loading=%0d, required addr=25 loading=%0d",
                   s_addr, consumed + int'(s_valid), NWIN - 1);
        end
        pulses++;
      end
      if (s_valid) begin
        e = exp_win(consumed);
        n_cmp++;
        if (s_win !== e) begin
          n_err++;
          $display("FAIL single_win[%0d]: got %h, required %h", consumed, s_win, e);
        end
        if (consumed == 0) begin
          n_cmp++;
          if (s_win[0][0] !== 8'd0 || s_win[1][0] !== 8'd28 || s_win[2][2] !== 8'd58) begin
            n_err++;
            $display("FAIL first_win: [0][0]=%0d [1][0]=%0d [2][2]=%0d, required 0/28/58",
                     s_win[0][0], s_win[1][0], s_win[2][2]);
          end
        end
        if (consumed == NWIN - 1) begin
          n_cmp++;
          if (s_win[0][0] !== 8'd213) begin
            n_err++;
            $display("FAIL last_win: [0][0]=%0d, required 213", s_win[0][0]);
          end
        end
`ifdef IM2COL_TAG_EN
        w = consumed % NWIN;
        n_cmp++;
        if (int'(s_row) != w / WPR || int'(s_col) != w % WPR || s_last !== (w == NWIN - 1)) begin
          n_err++;
          $display("FAIL tags[%0d]: row=%0d col=%0d last=%b, required %0d/%0d/%b",
                   consumed, s_row, s_col, s_last, w / WPR, w % WPR, w == NWIN - 1);
        end
`else
        w = 0;
`endif
        consumed++;
      end
    end
    n_cmp++;
    if (consumed != NWIN || pulses != 1) begin
      n_err++;
      $display("FAIL single_count: windows=%0d pulses=%0d, required %0d/1", consumed, pulses, NWIN);
    end
    repeat (3) tick(1'b1, 1'b0);
    n_cmp++;
    if (s_valid !== 1'b0) begin
      n_err++;
      $display("FAIL single_drain: valid=%b after image, required 0", s_valid);
    end
  endtask

  task automatic test_backpressure();
    win_t e;
    win_t held;
    bit   prev_hold;
    bit   rdy;
    int   stall_cnt;
    apply_reset();
    img_base[0] = int'($urandom_range(0, 255));
    img_base[1] = int'($urandom_range(0, 255));
    prev_hold = 1'b0;
    stall_cnt = 0;
    held      = '0;
    for (int t = 0; t < LIMIT && consumed < NWIN; t++) begin
      if (consumed == 30 && stall_cnt < 5) begin
        rdy = 1'b0;
        stall_cnt++;
      end else begin
        rdy = ($urandom_range(0, 3) != 0);
      end
      tick(rdy, pulses < 1);
      if (prev_hold) begin
        n_cmp++;
        if (s_valid !== 1'b1 || s_win !== held) begin
          n_err++;
          $display("FAIL bp_hold[%0d]: valid=%b win=%h, required 1 %h", consumed, s_valid, s_win, held);
        end
      end
      if (s_bready) begin
        n_cmp++;
        if (s_addr !== 5'd25 || ((consumed + int'(s_valid)) % NWIN) != NWIN - 1) begin
          n_err++;
          $display("FAIL bp_release: addr=%0d loading=%0d, required addr=25 loading=%0d",
                   s_addr, consumed + int'(s_valid), NWIN - 1);
        end
        pulses++;
      end
      if (s_valid && rdy) begin
        e = exp_win(consumed);
        n_cmp++;
        if (s_win !== e) begin
          n_err++;
          $display("FAIL bp_win[%0d]: got %h, required %h", consumed, s_win, e);
        end
        consumed++;
      end
      prev_hold = s_valid && !rdy;
      held      = s_win;
    end
    n_cmp++;
    if (consumed != NWIN || pulses != 1 || stall_cnt != 5) begin
      n_err++;
      $display("FAIL bp_count: windows=%0d pulses=%0d stalls=%0d, required %0d/1/5",
               consumed, pulses, stall_cnt, NWIN);
    end
  endtask

  task automatic test_back_to_back();
    win_t e;
    bit   started;
    int   gaps;
    apply_reset();
    img_base[0] = int'($urandom_range(0, 255));
    img_base[1] = int'($urandom_range(0, 255));
    img_base[2] = 0;
    started = 1'b0;
    gaps    = 0;
    for (int t = 0; t < LIMIT && consumed < 2 * NWIN; t++) begin
      tick(1'b1, pulses < 2);
      if (started && !s_valid) gaps++;
      if (s_bready) begin
        n_cmp++;
        if (s_addr !== 5'd25 || ((consumed + int'(s_valid)) % NWIN) != NWIN - 1) begin
          n_err++;
          $display("FAIL b2b_release: addr=%0d loading=%0d, required addr=25 loading mod %0d = %0d",
                   s_addr, consumed + int'(s_valid), NWIN, NWIN - 1);
        end
        pulses++;
      end
      if (s_valid) begin
        started = 1'b1;
        e = exp_win(consumed);
        n_cmp++;
        if (s_win !== e) begin
          n_err++;
          $display("FAIL b2b_win[%0d]: got %h, required %h", consumed, s_win, e);
        end
        consumed++;
      end
    end
    n_cmp++;
    if (consumed != 2 * NWIN || pulses != 2 || gaps != 0) begin
      n_err++;
      $display("FAIL b2b_count: windows=%0d pulses=%0d gaps=%0d, required %0d/2/0",
               consumed, pulses, gaps, 2 * NWIN);
    end
    repeat (3) tick(1'b1, 1'b0);
  endtask

  task automatic test_reset_mid_image();
    win_t e;
    apply_reset();
    img_base[0] = int'($urandom_range(0, 255));
    img_base[1] = int'($urandom_range(0, 255));
    for (int t = 0; t < LIMIT && consumed < 100; t++) begin
      tick(1'b1, 1'b1);
      if (s_valid) consumed++;
    end
    n_cmp++;
    if (consumed != 100) begin
      n_err++;
      $display("FAIL mid_reach: windows=%0d, required 100", consumed);
    end
    @(negedge i_clk);
    #2;
    i_rst = 1'b1;
    #1;
    n_cmp++;
    if (o_win_valid !== 1'b0 || o_addr !== 5'd0) begin
      n_err++;
      $display("FAIL mid_async_reset: valid=%b addr=%0d, required 0/0", o_win_valid, o_addr);
    end
    @(negedge i_clk);
    i_rst = 1'b0;
    clear_model();
    for (int t = 0; t < LIMIT && consumed < NWIN; t++) begin
      tick(1'b1, pulses < 1);
      if (s_bready) pulses++;
      if (s_valid) begin
        e = exp_win(consumed);
        n_cmp++;
        if (s_win !== e) begin
          n_err++;
          $display("FAIL restart_win[%0d]: got %h, required %h", consumed, s_win, e);
        end
        consumed++;
      end
    end
    n_cmp++;
    if (consumed != NWIN || pulses != 1) begin
      n_err++;
      $display("FAIL restart_count: windows=%0d pulses=%0d, required %0d/1", consumed, pulses, NWIN);
    end
  endtask

  initial begin
    img_base[0] = 0;
    img_base[1] = 0;
    img_base[2] = 0;
    img_base[3] = 0;
    test_reset();
    test_single_image();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_image();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
